// File: rtl/rv32i_types.sv
// Shared types for the RV32I core memory hierarchy.
//   CACHE_LINE_WIDTH : line width in bits, reused by both L1 caches and the arbiter
//   arb_state_t      : mem_arbiter FSM states
package rv32i_types;

  localparam int CACHE_LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port to one-port line arbiter between the I-cache miss path and the D-cache
// miss/writeback path. One whole line transaction is in flight at a time, and
// simultaneous requests are granted round-robin.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_read, i_address               I-side line read request (held until i_resp)
//   i_rdata, i_resp                 I-side read data / completion pulse
//   d_read, d_write, d_address,     D-side line read or writeback request
//   d_wdata                         (held until d_resp)
//   d_rdata, d_resp                 D-side read data / completion pulse
//   pmem_read, pmem_write,          memory strobes (held until pmem_resp),
//   pmem_address, pmem_wdata        address and write data
//   pmem_rdata, pmem_resp           memory read data / completion
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned LINE_WIDTH = CACHE_LINE_WIDTH,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t            state_q;
  logic                  last_grant_q;  // 0 = I, 1 = D
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;

  // Round-robin pick: on a tie the side that was not granted last wins.
  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign grant_d = d_req & (~i_req | ~last_grant_q);
  assign grant_i = i_req & ~grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          // pmem_resp here is stale or stray and deliberately ignored.
          if (grant_d) begin
            state_q      <= ARB_SERVE_D;
            last_grant_q <= 1'b1;
            addr_q       <= d_address;
            wdata_q      <= d_wdata;
            // Read and write together is illegal; write wins.
            pmem_write   <= d_write;
            pmem_read    <= d_read & ~d_write;
          end else if (grant_i) begin
            state_q      <= ARB_SERVE_I;
            last_grant_q <= 1'b0;
            addr_q       <= i_address;
            wdata_q      <= '0;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
          end
        end
        ARB_SERVE_I, ARB_SERVE_D: begin
          if (pmem_resp) begin
            state_q    <= ARB_IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state_q    <= ARB_IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Read data is a plain pass-through; only the resp pulse qualifies it.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;
  assign i_resp  = (state_q == ARB_SERVE_I) & pmem_resp;
  assign d_resp  = (state_q == ARB_SERVE_D) & pmem_resp;

  illegal_d_rw : assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write))
    else $warning("mem_arbiter: d_read and d_write both high, serving as write");

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized two-requester run against a
// transaction-level round-robin model.
module tb_mem_arbiter;
  import rv32i_types::*;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Memory model state
  int            mem_lat   = 1;
  int            mem_cnt   = 0;
  bit            stray     = 1'b0;
  bit            use_fixed = 1'b0;
  logic [LW-1:0] fixed_data;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = a ^ (32'h9E37_79B9 * 32'(i + 1));
    return r;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: memory reacts at the falling edge, outputs sampled 1 time unit later.
  task automatic tick();
    @(negedge clk);
    if (pmem_read || pmem_write) begin
      mem_cnt++;
      pmem_resp = (mem_cnt == mem_lat);
    end else begin
      mem_cnt   = 0;
      pmem_resp = stray;
    end
    pmem_rdata = use_fixed ? fixed_data : line_of(pmem_address);
    #1;
  endtask

  typedef struct {
    int            start;
    int            resp;
    bit            side_d;
    bit            wr;
    bit            both;
    bit            dual_resp;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } txn_obs_t;

  // Cycle numbers are relative to the cycle in which the caller set up requests (cycle 0).
  task automatic do_txn(output txn_obs_t o);
    o.start = -1; o.resp = -1; o.side_d = 1'b0; o.wr = 1'b0; o.both = 1'b0;
    o.dual_resp = 1'b0; o.addr = '0; o.wdata = '0; o.rdata = '0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if ((pmem_read || pmem_write) && o.start < 0) begin
        o.start = c;
        o.wr    = pmem_write;
        o.both  = pmem_read && pmem_write;
        o.addr  = pmem_address;
        o.wdata = pmem_wdata;
      end
      if (i_resp || d_resp) begin
        o.resp      = c;
        o.side_d    = d_resp;
        o.dual_resp = i_resp && d_resp;
        o.rdata     = d_resp ? d_rdata : i_rdata;
        return;
      end
    end
  endtask

  task automatic drop_all();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  typedef struct {
    bit            ir, dr, dw;
    logic [AW-1:0] ia, da;
    logic [LW-1:0] wd;
    int            lat;
    bit            exp_d;
    bit            exp_wr;
  } vec_t;

  vec_t     vt[7];
  txn_obs_t o;

  initial begin
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_rd;
    // random-phase state
    bit            ip, dp, rq_dw, mlast, busy, cur_d, prev_ip, prev_dp, strobe;
    int            igap, dgap, iwait, dwait, done;
    logic [AW-1:0] rq_ia, rq_da;
    logic [LW-1:0] rq_wd;

    fixed_data = {32{8'hA5}};
    // Expected grants follow from last_grant starting at I after reset.
    vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, '0, 4, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_2040, {8{32'h1234_5678}}, 3, 1'b1, 1'b1};
    vt[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'h0000_5000, '0, 2, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_6000, 32'h0000_7000, {8{32'hDEAD_BEEF}}, 1, 1'b1, 1'b1};
    vt[4] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_8000, '0, 5, 1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_9000, 32'h0000_A000, '0, 2, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_3000, {8{32'h0BAD_F00D}}, 3, 1'b1, 1'b1};

    rst_n = 1'b0; drop_all(); i_address = '0; d_address = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    tick();
    check("reset_strobes_resps", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0);
    check("reset_address", pmem_address, '0);
    check("reset_wdata", pmem_wdata, '0);
    rst_n = 1'b1;
    tick();
    check("idle_strobes_resps", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0);

    // Directed vector table
    for (int v = 0; v < 7; v++) begin
      use_fixed = (v == 0);
      mem_lat   = vt[v].lat;
      i_read = vt[v].ir; i_address = vt[v].ia;
      d_read = vt[v].dr; d_write = vt[v].dw; d_address = vt[v].da; d_wdata = vt[v].wd;
      do_txn(o);
      drop_all();
      exp_addr = vt[v].exp_d ? vt[v].da : vt[v].ia;
      exp_rd   = (v == 0) ? fixed_data : line_of(exp_addr);
      check($sformatf("v%0d_start", v), LW'(o.start), LW'(1));
      check($sformatf("v%0d_resp_cycle", v), LW'(o.resp), LW'(vt[v].lat));
      check($sformatf("v%0d_side", v), LW'(o.side_d), LW'(vt[v].exp_d));
      check($sformatf("v%0d_write", v), LW'(o.wr), LW'(vt[v].exp_wr));
      check($sformatf("v%0d_rd_wr_both", v), LW'(o.both), '0);
      check($sformatf("v%0d_dual_resp", v), LW'(o.dual_resp), '0);
      check($sformatf("v%0d_address", v), LW'(o.addr), LW'(exp_addr));
      if (vt[v].exp_wr) check($sformatf("v%0d_wdata", v), o.wdata, vt[v].wd);
      check($sformatf("v%0d_rdata", v), o.rdata, exp_rd);
      tick();
      check($sformatf("v%0d_bubble", v), {pmem_read, pmem_write, i_resp, d_resp}, 4'b0);
      use_fixed = 1'b0;
    end

    // Simultaneous requests straight after reset: D first, then I after one bubble.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    mem_lat = 3;
    i_read = 1'b1; i_address = 32'h0000_0100; d_read = 1'b1; d_address = 32'h0000_0200;
    do_txn(o);
    d_read = 1'b0;
    check("tie_first_side", LW'(o.side_d), LW'(1));
    check("tie_first_addr", LW'(o.addr), LW'(32'h0000_0200));
    do_txn(o);
    i_read = 1'b0;
    check("tie_second_side", LW'(o.side_d), LW'(0));
    check("tie_second_start", LW'(o.start), LW'(2));
    check("tie_second_addr", LW'(o.addr), LW'(32'h0000_0100));
    tick();

    // Continuous requests from both sides alternate, starting with D.
    mem_lat = 2;
    i_read = 1'b1; d_read = 1'b1;
    for (int k = 0; k < 6; k++) begin
      do_txn(o);
      check($sformatf("alt%0d_side", k), LW'(o.side_d), LW'(k % 2 == 0));
      check($sformatf("alt%0d_start", k), LW'(o.start), LW'((k == 0) ? 1 : 2));
    end
    drop_all();
    tick();

    // Reset in the middle of a 5-cycle writeback.
    mem_lat = 5;
    d_write = 1'b1; d_address = 32'h0000_2000; d_wdata = {8{32'hCAFE_0001}};
    tick(); tick();
    check("midrst_pre_strobe", LW'(pmem_write), LW'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_strobes_resps", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0);
    check("midrst_address", pmem_address, '0);
    check("midrst_wdata", pmem_wdata, '0);
    drop_all();
    tick(); rst_n = 1'b1; tick();
    mem_lat = 2;
    i_read = 1'b1; i_address = 32'h0000_1100;
    do_txn(o);
    i_read = 1'b0;
    check("postrst_side", LW'(o.side_d), LW'(0));
    check("postrst_start", LW'(o.start), LW'(1));
    check("postrst_resp", LW'(o.resp), LW'(2));
    check("postrst_rdata", o.rdata, line_of(32'h0000_1100));

    // pmem_resp held or stray while idle produces nothing.
    stray = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stray%0d", k), {pmem_read, pmem_write, i_resp, d_resp}, 4'b0);
    end
    stray = 1'b0;
    tick();

    // Randomized run against a transaction-level round-robin model.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    mlast = 1'b0; busy = 1'b0; cur_d = 1'b0; ip = 1'b0; dp = 1'b0; rq_dw = 1'b0;
    igap = 0; dgap = 0; iwait = 0; dwait = 0; done = 0;
    prev_ip = 1'b0; prev_dp = 1'b0; rq_ia = '0; rq_da = '0; rq_wd = '0;
    mem_lat = $urandom_range(1, 6);
    for (int cyc = 0; cyc < 5000 && done < 150; cyc++) begin
      tick();
      strobe = pmem_read || pmem_write;
      if (strobe && !busy) begin
        check("rnd_grant_has_request", LW'(prev_ip || prev_dp), LW'(1));
        cur_d = (prev_ip && prev_dp) ? !mlast : prev_dp;
        mlast = cur_d;
        busy  = 1'b1;
        check("rnd_address", LW'(pmem_address), LW'(cur_d ? rq_da : rq_ia));
        check("rnd_write", LW'(pmem_write), LW'(cur_d && rq_dw));
        check("rnd_read", LW'(pmem_read), LW'(!(cur_d && rq_dw)));
        if (cur_d && rq_dw) check("rnd_wdata", pmem_wdata, rq_wd);
      end
      if (i_resp || d_resp || busy && pmem_resp) begin
        check("rnd_resp_side", {i_resp, d_resp}, busy ? (cur_d ? 2'b01 : 2'b10) : 2'b00);
        check("rnd_rdata", cur_d ? d_rdata : i_rdata, line_of(cur_d ? rq_da : rq_ia));
        busy = 1'b0;
        done++;
        mem_lat = $urandom_range(1, 6);
        if (cur_d) begin
          d_read = 1'b0; d_write = 1'b0; dp = 1'b0; dgap = $urandom_range(1, 4);
        end else begin
          i_read = 1'b0; ip = 1'b0; igap = $urandom_range(1, 4);
        end
      end
      if (!ip) begin
        if (igap > 0) igap--;
        else if ($urandom_range(0, 2) == 0) begin
          ip = 1'b1; iwait = 0;
          rq_ia = $urandom() & 32'hFFFF_FFE0;
          i_read = 1'b1; i_address = rq_ia;
        end
      end else if (++iwait > 60) begin
        check("rnd_starve_i", LW'(iwait), LW'(60));
        break;
      end
      if (!dp) begin
        if (dgap > 0) dgap--;
        else if ($urandom_range(0, 2) == 0) begin
          dp = 1'b1; dwait = 0;
          rq_dw = 1'($urandom_range(0, 1));
          rq_da = $urandom() & 32'hFFFF_FFE0;
          rq_wd = rand_line();
          d_read = !rq_dw; d_write = rq_dw; d_address = rq_da; d_wdata = rq_wd;
        end
      end else if (++dwait > 60) begin
        check("rnd_starve_d", LW'(dwait), LW'(60));
        break;
      end
      prev_ip = i_read;
      prev_dp = d_read || d_write;
    end
    check("rnd_completed", LW'(done >= 150), LW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
